truth_table_sweeper: RTL and testbench

//  Characterises a combinational N-input/1-output logic block, such as a synthesised

---
 rtl/truth_table_pkg.sv | 12 +
 rtl/tt_settle_counter.sv | 18 +
 rtl/truth_table_sweeper.sv | 115 +++++++++++
 tb/tb_truth_table_sweeper.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared types and bit-ordering helpers for the truth-table sweeper.
package truth_table_pkg;
   typedef enum logic {IDLE, SETTLE} state_t;
   localparam int SETTLE_W = 8;
   function automatic int rows(input int n);
      return 1 << n;
   endfunction
   // Row k (first input = MSB of stim) lands in the word bit counted from the top.
   function automatic int row_bit(input int k, input int n);
      return rows(n) - 1 - k;
   endfunction
endpackage

// File: rtl/tt_settle_counter.sv
// tt_settle_counter: loadable down-counter with a zero flag, sets per-row hold time.
module tt_settle_counter
   import truth_table_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                dec,
   input  logic [SETTLE_W-1:0] load_val,
   output logic                is_zero
);
   logic [SETTLE_W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - 1'b1;
   assign is_zero = cnt == '0;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input row of a combinational block, samples its
// response after a settle time and packs the results into a checked function word.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int N_INPUTS      = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [rows(N_INPUTS)-1:0]     expect_table,
   input  logic                          resp,
   output logic [N_INPUTS-1:0]           stim,
   output logic                          busy,
   output logic                          done,
   output logic [rows(N_INPUTS)-1:0]     table_out,
   output logic                          table_valid,
   output logic                          match
);
   localparam int W = rows(N_INPUTS);
   state_t              state, state_d;
   logic [N_INPUTS:0]   row, row_d;
   logic [W-1:0]        shadow, shadow_d, exp_q, exp_d, table_d, final_word;
   logic [N_INPUTS-1:0] stim_d, idx;
   logic                busy_d, done_d, valid_d, match_d, load, dec, is_zero, last;
   tt_settle_counter u_settle (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .dec      (dec),
      .load_val (SETTLE_W'(SETTLE_CYCLES)),
      .is_zero  (is_zero)
   );
   assign idx  = N_INPUTS'(row_bit(int'(row), N_INPUTS));
   assign last = row == (N_INPUTS+1)'(W - 1);
   // The sampled bit is folded in here so the final word includes the last row.
   always_comb begin
      final_word      = shadow;
      final_word[idx] = resp;
   end
   always_comb begin
      state_d  = state;
      row_d    = row;
      shadow_d = shadow;
      exp_d    = exp_q;
      stim_d   = stim;
      busy_d   = busy;
      done_d   = 1'b0;
      table_d  = table_out;
      valid_d  = table_valid;
      match_d  = match;
      load     = 1'b0;
      dec      = 1'b0;
      if (state == IDLE) begin
         if (start && !abort) begin
            state_d = SETTLE;
            busy_d  = 1'b1;
            stim_d  = '0;
            row_d   = '0;
            load    = 1'b1;
            exp_d   = expect_table;
            valid_d = 1'b0;
         end
      end else if (abort) begin
         state_d = IDLE;
         busy_d  = 1'b0;
         stim_d  = '0;
         row_d   = '0;
      end else if (!is_zero) begin
         dec = 1'b1;
      end else begin
         shadow_d = final_word;
         if (!last) begin
            row_d  = row + 1'b1;
            stim_d = row_d[N_INPUTS-1:0];
            load   = 1'b1;
         end else begin
            state_d = IDLE;
            table_d = final_word;
            match_d = final_word == exp_q;
            valid_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            stim_d  = '0;
            row_d   = '0;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         row         <= '0;
         shadow      <= '0;
         exp_q       <= '0;
         stim        <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         table_out   <= '0;
         table_valid <= 1'b0;
         match       <= 1'b0;
      end else begin
         state       <= state_d;
         row         <= row_d;
         shadow      <= shadow_d;
         exp_q       <= exp_d;
         stim        <= stim_d;
         busy        <= busy_d;
         done        <= done_d;
         table_out   <= table_d;
         table_valid <= valid_d;
         match       <= match_d;
      end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: scoreboard bench over three sweeper configurations.
module tb_truth_table_sweeper;
   import truth_table_pkg::*;
   typedef struct {
      int          g;
      logic [15:0] tab;
      logic        m;
      int          blen;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_v[3], abort_v[3], busy_v[3], done_v[3], valid_v[3], match_v[3];
   logic [15:0] expv[3], fn_v[3], tab_v[3];
   logic [3:0]  stim_v[3];
   int          mode_v[3];
   int          errs = 0, checks = 0;
   exp_t        sbq[$];
   always #5 clk = ~clk;
   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s got=%0h want=%0h", n, a, e);
      end
   endtask
   // Reference functions: 0 NAND, 1 AND, 2 OR, 3 XOR (odd parity), else arbitrary table.
   function automatic logic f(input int md, input logic [15:0] fn, input int n, input int k);
      int all;
      all = (1 << n) - 1;
      case (md)
         0: return k != all;
         1: return k == all;
         2: return k != 0;
         3: return ($countones(k) % 2) == 1;
         default: return fn[all - k];
      endcase
   endfunction
   function automatic logic [15:0] model(input int md, input logic [15:0] fn, input int n);
      logic [15:0] t;
      t = '0;
      for (int k = 0; k < (1 << n); k++)
         if (f(md, fn, n, k)) t[(1 << n) - 1 - k] = 1'b1;
      return t;
   endfunction
   for (genvar g = 0; g < 3; g++) begin : u
      localparam int N = (g == 2) ? 2 : 4;
      localparam int S = (g == 1) ? 0 : 2;
      localparam int W = 1 << N;
      logic [N-1:0] st;
      logic [W-1:0] tb_o;
      logic         bz, dn, vl, mt, rs, pb, pd;
      int           blen;
      exp_t         e;
      assign rs = f(mode_v[g], fn_v[g], N, int'(st));
      truth_table_sweeper #(.N_INPUTS(N), .SETTLE_CYCLES(S)) dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .start        (start_v[g]),
         .abort        (abort_v[g]),
         .expect_table (expv[g][W-1:0]),
         .resp         (rs),
         .stim         (st),
         .busy         (bz),
         .done         (dn),
         .table_out    (tb_o),
         .table_valid  (vl),
         .match        (mt)
      );
      assign stim_v[g]  = 4'(st);
      assign tab_v[g]   = 16'(tb_o);
      assign busy_v[g]  = bz;
      assign done_v[g]  = dn;
      assign valid_v[g] = vl;
      assign match_v[g] = mt;
      always @(negedge clk) begin
         if (!rst_n) begin
            blen = 0;
            pb   = 1'b0;
            pd   = 1'b0;
         end else begin
            if (pd) check($sformatf("u%0d.done_width", g), dn, 0);
            if (bz) blen++;
            if (dn) begin
               if (sbq.size() == 0) begin
                  checks++;
                  errs++;
                  $display("FAIL u%0d.unexpected_done got=1 want=0", g);
               end else begin
                  e = sbq.pop_front();
                  check($sformatf("u%0d.tag", g), g, e.g);
                  check($sformatf("u%0d.table", g), tb_o, e.tab);
                  check($sformatf("u%0d.match", g), mt, e.m);
                  check($sformatf("u%0d.valid", g), vl, 1);
                  check($sformatf("u%0d.busy_at_done", g), bz, 0);
                  check($sformatf("u%0d.busy_len", g), blen, e.blen);
               end
               blen = 0;
            end else if (pb && !bz) blen = 0;
            pb = bz;
            pd = dn;
         end
      end
   end
   task automatic go(input int g, input logic [15:0] e);
      @(posedge clk) #1;
      start_v[g] = 1'b1;
      expv[g]    = e;
      @(posedge clk) #1;
      start_v[g] = 1'b0;
   endtask
   task automatic wait_idle(input int g, input int lim);
      int c;
      c = 0;
      while (busy_v[g] && c < lim) begin
         @(posedge clk) #1;
         c++;
      end
      if (busy_v[g]) check($sformatf("u%0d.timeout", g), 1, 0);
      repeat (3) @(posedge clk);
   endtask
   task automatic check_clear(input int g, input string n);
      check({n, ".stim"}, stim_v[g], 0);
      check({n, ".busy"}, busy_v[g], 0);
      check({n, ".done"}, done_v[g], 0);
      check({n, ".table"}, tab_v[g], 0);
      check({n, ".valid"}, valid_v[g], 0);
      check({n, ".match"}, match_v[g], 0);
   endtask
   initial begin
      int          g, n, s, md;
      logic [15:0] m, e;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         abort_v[i] = 1'b0;
         expv[i]    = '0;
         fn_v[i]    = '0;
         mode_v[i]  = 0;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) check_clear(i, $sformatf("reset%0d", i));
      @(posedge clk) #1 rst_n = 1'b1;
      // NAND4 and AND4 on the default configuration
      sbq.push_back('{0, 16'hFFFE, 1'b1, 48});
      go(0, 16'hFFFE);
      wait_idle(0, 200);
      mode_v[0] = 1;
      sbq.push_back('{0, 16'h0001, 1'b0, 48});
      go(0, 16'hFFFE);
      wait_idle(0, 200);
      // OR4 with no settle time: stim advances every cycle
      mode_v[1] = 2;
      sbq.push_back('{1, 16'h7FFF, 1'b1, 16});
      go(1, 16'h7FFF);
      for (int k = 0; k < 16; k++) begin
         check($sformatf("u1.stim_row%0d", k), stim_v[1], k);
         @(posedge clk) #1;
      end
      wait_idle(1, 50);
      // abort mid-sweep
      mode_v[0] = 0;
      go(0, 16'hFFFE);
      repeat (19) @(posedge clk) #1;
      abort_v[0] = 1'b1;
      @(posedge clk) #1;
      abort_v[0] = 1'b0;
      check("abort.busy", busy_v[0], 0);
      check("abort.stim", stim_v[0], 0);
      check("abort.valid", valid_v[0], 0);
      repeat (60) @(posedge clk);
      // abort on the final sample edge discards the result
      go(0, 16'hFFFE);
      repeat (47) @(posedge clk) #1;
      check("final_edge.busy_before", busy_v[0], 1);
      abort_v[0] = 1'b1;
      @(posedge clk) #1;
      abort_v[0] = 1'b0;
      check("final_edge.busy", busy_v[0], 0);
      check("final_edge.done", done_v[0], 0);
      check("final_edge.valid", valid_v[0], 0);
      repeat (5) @(posedge clk);
      // start together with abort in IDLE is refused
      @(posedge clk) #1;
      start_v[0] = 1'b1;
      abort_v[0] = 1'b1;
      @(posedge clk) #1;
      start_v[0] = 1'b0;
      abort_v[0] = 1'b0;
      check("start_abort.busy", busy_v[0], 0);
      // restart after abort; a second start mid-sweep must not recapture expect
      sbq.push_back('{0, 16'hFFFE, 1'b1, 48});
      go(0, 16'hFFFE);
      repeat (8) @(posedge clk);
      go(0, 16'h0000);
      wait_idle(0, 200);
      check("restart.valid_held", valid_v[0], 1);
      // reset mid-sweep clears everything at once
      go(0, 16'hFFFE);
      repeat (28) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_clear(0, "midreset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      // XOR2 on the two-input configuration
      mode_v[2] = 3;
      sbq.push_back('{2, 16'h0006, 1'b1, 12});
      go(2, 16'h0006);
      wait_idle(2, 100);
      // randomized functions and expect words against the reference model
      for (int i = 0; i < 8; i++) begin
         g  = $urandom_range(0, 2);
         n  = (g == 2) ? 2 : 4;
         s  = (g == 1) ? 0 : 2;
         md = $urandom_range(0, 4);
         mode_v[g] = md;
         fn_v[g]   = 16'($urandom);
         m = model(md, fn_v[g], n);
         e = ($urandom_range(0, 1) == 1) ? m : (16'($urandom) & 16'((1 << n) - 1));
         sbq.push_back('{g, m, e == m, rows(n) * (s + 1)});
         go(g, e);
         wait_idle(g, 200);
      end
      check("scoreboard_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
